// File: rtl/spi_slave_cpu_pkg.sv
// Shared types and constants for the memory-mapped SPI responder.
package spi_slave_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_HIGH = 2'd2
  } state_e;

  // Status register bit positions
  localparam int unsigned STAT_RX_VALID  = 0;
  localparam int unsigned STAT_BUSY      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;
  localparam int unsigned STAT_IRQ_EN    = 7;

  // The status register sits directly after the N data bytes.
  function automatic int unsigned status_offset(input int unsigned bytes_per_txn);
    return bytes_per_txn;
  endfunction

endpackage

// File: rtl/spi_slave_cpu_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input with registered
// single-cycle rise/fall pulses in the clk_i domain.
module sync_edge_detect
  import spi_slave_cpu_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Synchronizer chain and edge pulse generation
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  // Synchronizer and pulse registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_cpu.sv
// Memory-mapped SPI mode-0 responder: receives fixed-length frames from an
// external master into CPU-readable RX bytes and shifts CPU-written TX bytes
// out on MISO, with status flags and a level interrupt.
module spi_slave_cpu
  import spi_slave_cpu_pkg::*;
#(
  parameter int unsigned BaseAddress         = 'h0000,
  parameter int unsigned BytesPerTransaction = 4,
  parameter int unsigned address_width       = 16,
  parameter int unsigned data_width          = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o,
  input  logic                     spi_clk_i,
  input  logic                     spi_mosi_i,
  input  logic                     spi_sync_ni,
  output logic                     spi_miso_o
);

  localparam int unsigned N     = BytesPerTransaction;
  // byte_idx must reach N+1 so an over-long frame never looks complete
  localparam int unsigned IDX_W = $clog2(N + 2);
  localparam int unsigned ARR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]         N_IDX    = IDX_W'(N);
  localparam logic [address_width-1:0] BASE     = address_width'(BaseAddress);
  localparam logic [address_width-1:0] STAT_OFF = address_width'(status_offset(N));

  // Conditioned SPI inputs
  logic unused_sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;
  logic sync_level, sync_rise, sync_fall;

  sync_edge_detect u_sclk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (spi_clk_i),
    .sync_o  (unused_sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge_detect u_mosi (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (spi_mosi_i),
    .sync_o  (mosi_level),
    .rise_o  (unused_mosi_rise),
    .fall_o  (unused_mosi_fall)
  );

  sync_edge_detect u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (spi_sync_ni),
    .sync_o  (sync_level),
    .rise_o  (sync_rise),
    .fall_o  (sync_fall)
  );

  // Architectural state
  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            tx_shift_q, tx_shift_d;
  logic                  miso_q, miso_d;
  logic [7:0]            tx_q       [N];
  logic [7:0]            tx_d       [N];
  logic [7:0]            rx_q       [N];
  logic [7:0]            rx_d       [N];
  logic [7:0]            rx_stage_q [N];
  logic [7:0]            rx_stage_d [N];
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [data_width-1:0] data_q, data_d;

  // Bus decode
  logic [address_width-1:0] off;
  logic [ARR_W-1:0]         off_idx;
  logic                     in_range, wr_en, rd_en, stat_sel;
  logic [7:0]               status_byte;
  logic [7:0]               rx_next;

  assign off      = address_i - BASE;
  assign off_idx  = ARR_W'(off);
  assign in_range = (address_i >= BASE) && (off <= STAT_OFF);
  assign wr_en    = in_range & rd_wr_i;
  assign rd_en    = in_range & ~rd_wr_i;
  assign stat_sel = (off == STAT_OFF);

  // Next-state, datapath and register-interface logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rx_stage_d  = rx_stage_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    irq_en_d    = irq_en_q;
    data_d      = data_q;
    rx_next     = {rx_shift_q[6:0], mosi_level};

    status_byte                 = '0;
    status_byte[STAT_RX_VALID]  = rx_valid_q;
    status_byte[STAT_BUSY]      = (state_q == ACTIVE);
    status_byte[STAT_OVERRUN]   = overrun_q;
    status_byte[STAT_FRAME_ERR] = frame_err_q;
    status_byte[STAT_IRQ_EN]    = irq_en_q;

    // CPU side: clears are applied first so frame events below override them
    if (wr_en) begin
      if (stat_sel) begin
        if (data_i[STAT_RX_VALID])  rx_valid_d  = 1'b0;
        if (data_i[STAT_OVERRUN])   overrun_d   = 1'b0;
        if (data_i[STAT_FRAME_ERR]) frame_err_d = 1'b0;
        irq_en_d = data_i[STAT_IRQ_EN];
      end else begin
        tx_d[off_idx] = 8'(data_i);
      end
    end

    if (rd_en) begin
      data_d = stat_sel ? data_width'(status_byte) : data_width'(rx_q[off_idx]);
    end

    irq_d = irq_en_q & rx_valid_q;

    case (state_q)
      WAIT_HIGH: begin
        miso_d = 1'b0;
        if (sync_level) state_d = IDLE;
      end

      IDLE: begin
        miso_d = 1'b0;
        if (sync_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          tx_shift_d = tx_q[0];
          miso_d     = tx_q[0][7];
        end
      end

      ACTIVE: begin
        if (sync_rise) begin
          state_d = IDLE;
          miso_d  = 1'b0;
          if ((byte_idx_q == N_IDX) && (bit_cnt_q == 3'd0)) begin
            // rx_valid_d already reflects a same-cycle CPU clear
            if (rx_valid_d) begin
              overrun_d = 1'b1;
            end else begin
              rx_d       = rx_stage_q;
              rx_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_idx_q < N_IDX) rx_stage_d[ARR_W'(byte_idx_q)] = rx_next;
            if (byte_idx_q <= N_IDX) byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) begin
            tx_shift_d = (byte_idx_q < N_IDX) ? tx_q[ARR_W'(byte_idx_q)] : 8'h00;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
          miso_d = tx_shift_d[7];
        end
      end

      default: begin
        state_d = WAIT_HIGH;
        miso_d  = 1'b0;
      end
    endcase
  end

  // Frame state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= WAIT_HIGH;
    else         state_q <= state_d;
  end

  // Datapath, buffers and CPU-visible registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      data_q      <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        tx_q[k]       <= '0;
        rx_q[k]       <= '0;
        rx_stage_q[k] <= '0;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rx_stage_q  <= rx_stage_d;
    end
  end

  assign data_o     = data_q;
  assign irq_o      = irq_q;
  assign spi_miso_o = miso_q;

endmodule
